pipe_reg_elastic: RTL and testbench
===================================

# pipe_reg_elastic

Parametrised elastic pipeline register, the successor to the fixed-field, always-advancing stage registers between pipeline stages. It carries an opaque DATA_W-bit payload (the stage fields packed by the instantiating stage) under a valid/ready handshake. It provides stall back-pressure through an optional skid entry, a synchronous flush, and a saturating stall-cycle performance counter. It is instantiated between any two pipeline stages: issue→execute, execute→memory, memory→writeback.

## Interface
- DATA_W, 32: payload width in bits; legal range 1..512.
- SKID, 1: selects the stage depth.
  - 1: two-entry stage (main + skid); ready_o is a registered signal.
  - 0: single-entry stage; ready_o is combinational from ready_i.
- CNT_W, 16: width of the stall counter.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush; kills all held entries.
- valid_i  in  1  upstream payload valid.
- ready_o  out  1  stage can accept this cycle.
- data_i  in  DATA_W  upstream payload.
- valid_o  out  1  main entry valid toward downstream.
- ready_i  in  1  downstream accepts this cycle.
- data_o  out  DATA_W  main entry payload.
- occ_o  out  2  number of held entries (0..2; maximum 1 when SKID=0).
- stall_cnt_clr  in  1  synchronous clear of the stall counter.
- stall_cnt_o  out  CNT_W  count of cycles with valid_o=1 and ready_i=0.

## Operation
- Definitions:
  - acc = valid_i & ready_o
  - deq = valid_o & ready_i
- State is encoded by occupancy:
  - EMPTY: occ=0
  - BUSY: main valid, skid empty; occ=1
  - FULL: main and skid valid; occ=2; reachable only when SKID=1.
- SKID=1, ready_o = !skid_valid (registered):
  - EMPTY: acc → main<=data_i, go to BUSY.
  - BUSY, acc&deq: main<=data_i, stay in BUSY.
  - BUSY, acc&!deq: skid<=data_i, go to FULL.
  - BUSY, !acc&deq: go to EMPTY.
  - BUSY, !acc&!deq: hold.
  - FULL: ready_o=0. deq → main<=skid, go to BUSY; otherwise hold.
- SKID=0, ready_o = ready_i | !valid_o:
  - acc → main<=data_i, valid stays 1.
  - deq & !acc → go to EMPTY.
- Ordering is strictly FIFO. The skid entry is always younger than the main entry.
- clr:
  - Takes priority over acc and deq in the same cycle.
  - Next state is EMPTY; main and skid data registers are zeroed; occ_o=0.
  - The payload presented on the clr cycle is dropped. The upstream sees acc if ready_o was 1; the entry is discarded anyway.
- Stall counter:
  - Increments by 1 on each cycle where valid_o & !ready_i.
  - Saturates at 2^CNT_W-1; no wrap.
  - stall_cnt_clr has priority over increment; the counter reads 0 the next cycle.
  - clr does not affect the counter.
- reset (asynchronous):
  - valid_o=0, data_o=0, occ_o=0, stall_cnt_o=0, skid valid=0, skid data=0.
  - ready_o=1 in both modes.
  - Assertion mid-transfer discards all entries immediately, without waiting for a clock edge.
- Data registers load only on acc (or skid→main transfer). No enable toggling while holding.

## Timing
- Latency: data_i accepted at edge N appears on data_o after edge N (one cycle).
- Throughput: one transfer per cycle when ready_i is held high, in both modes.
- data_o and valid_o are stable while valid_o=1 & ready_i=0. valid_o never drops without deq, clr or reset.
- SKID=1: no combinational path from ready_i to ready_o; ready_o falls the cycle after FULL is entered.
- SKID=0: combinational path ready_i → ready_o; intended for short local hops only.
- Simultaneous cases:
  - acc and deq in FULL cannot occur, because ready_o=0.
  - acc and deq in BUSY keeps occupancy at 1; new data replaces the departing main entry.
  - clr together with reset: reset wins.
  - stall_cnt_clr on a stall cycle: counter reads 0 next cycle; the increment is lost.

## Test plan
- Reset and idle, SKID=1, DATA_W=32: assert reset mid-cycle → outputs go to zero immediately, no clock required; after deassert, valid_o=0, ready_o=1, occ_o=0, stall_cnt_o=0.
- Streaming, SKID=1: drive 0x1..0x8 back-to-back with ready_i=1 → data_o shows 0x1..0x8 on consecutive cycles, one cycle after each accept; occ_o=1 throughout.
- Back-pressure, SKID=1: send 0xA then 0xB, with ready_i=0 from the cycle 0xA reaches data_o.
  - Required: occ_o=2, ready_o=0 the next cycle, stall_cnt_o increments each stalled cycle, data_o holds 0xA.
  - Then raise ready_i: 0xA then 0xB leave in order; ready_o returns to 1 one cycle after the first deq.
- Flush, SKID=1: in FULL holding 0xA/0xB, assert clr together with ready_i=1 → next cycle valid_o=0, occ_o=0, data_o=0; 0xA is not consumed; stall_cnt_o is unchanged.
- SKID=0, DATA_W=96: hold ready_i=0 with valid_o=1 → ready_o=0 the same cycle; pulse ready_i with valid_i=1 (payload 0x123456789ABCDEF012345678) → replacement without a bubble, occ_o stays 1.
- Counter saturation, CNT_W=4: stall 20 cycles → stall_cnt_o stops at 15; pulse stall_cnt_clr during the stall → reads 0 the next cycle, then resumes at 1.

Source files
------------

// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register: valid/ready stage with optional skid entry,
// synchronous flush and a saturating stall-cycle counter.
module pipe_reg_elastic #(
    parameter int unsigned DATA_W = 32,
    parameter bit          SKID   = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        occ_o,
    input  logic              stall_cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // State is the occupancy itself, so occ_o is the state register.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              acc;
    logic              deq;
    logic              load_main;
    logic              load_skid;
    logic              skid_to_main;

    assign acc = valid_i & ready_o;
    assign deq = valid_o & ready_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and datapath load controls; flush overrides any transfer.
    always_comb begin
        state_nxt    = state;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (clr) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        state_nxt = BUSY;
                        load_main = 1'b1;
                    end
                end
                BUSY: begin
                    if (acc && deq) begin
                        load_main = 1'b1;
                    end else if (acc) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end else if (deq) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (deq) begin
                        state_nxt    = BUSY;
                        skid_to_main = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Without a skid entry the stage is ready whenever its entry is leaving.
    always_comb begin
        valid_o = (state != EMPTY);
        occ_o   = state;
        data_o  = main_q;
        if (SKID) begin
            ready_o = (state != FULL);
        end else begin
            ready_o = ready_i | (state == EMPTY);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (clr) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= data_i;
            end else if (skid_to_main) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= data_i;
            end
        end
    end

    // Stall counter: saturating, independent of flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (stall_cnt_clr) begin
            cnt_q <= '0;
        end else if (valid_o && !ready_i && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Randomised and directed bench for pipe_reg_elastic, one skid and one
// skid-less instance, both checked against a queue-style occupancy model.
module tb_pipe_reg_elastic;

    localparam int unsigned CW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  clr;
    logic [1:0]  vin;
    logic [1:0]  rin;
    logic [1:0]  scc;
    logic [95:0] din [2];

    logic          vout1, rout1, vout0, rout0;
    logic [31:0]   dout1;
    logic [95:0]   dout0;
    logic [1:0]    occ1, occ0;
    logic [CW-1:0] cnt1, cnt0;

    int n_checks = 0;
    int n_errs   = 0;

    // Model: held entries in arrival order, last shown payload, stall count.
    logic [95:0] ment  [2][2];
    int          mcnt  [2];
    logic [95:0] mlast [2];
    int          mstall[2];

    always #5 clk = ~clk;

    pipe_reg_elastic #(.DATA_W(32), .SKID(1'b1), .CNT_W(CW)) u_dut_skid (
        .clk(clk), .reset(reset), .clr(clr[1]),
        .valid_i(vin[1]), .ready_o(rout1), .data_i(din[1][31:0]),
        .valid_o(vout1), .ready_i(rin[1]), .data_o(dout1),
        .occ_o(occ1), .stall_cnt_clr(scc[1]), .stall_cnt_o(cnt1)
    );

    pipe_reg_elastic #(.DATA_W(96), .SKID(1'b0), .CNT_W(CW)) u_dut_flat (
        .clk(clk), .reset(reset), .clr(clr[0]),
        .valid_i(vin[0]), .ready_o(rout0), .data_i(din[0]),
        .valid_o(vout0), .ready_i(rin[0]), .data_o(dout0),
        .occ_o(occ0), .stall_cnt_clr(scc[0]), .stall_cnt_o(cnt0)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic mrdy(input int k);
        if (k == 1) return (mcnt[1] < 2);
        return rin[0] || (mcnt[0] == 0);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0; mlast[k] = '0; mstall[k] = 0;
            ment[k][0] = '0; ment[k][1] = '0;
        end
    endtask

    task automatic model_step(input int k);
        logic        acc, deq;
        logic [95:0] d;
        d   = (k == 1) ? {64'b0, din[1][31:0]} : din[0];
        acc = vin[k] && mrdy(k);
        deq = (mcnt[k] > 0) && rin[k];
        if (scc[k]) mstall[k] = 0;
        else if ((mcnt[k] > 0) && !rin[k] && (mstall[k] < 15)) mstall[k]++;
        if (clr[k]) begin
            mcnt[k] = 0; mlast[k] = '0;
        end else begin
            if (deq) begin ment[k][0] = ment[k][1]; mcnt[k]--; end
            if (acc) begin ment[k][mcnt[k]] = d; mcnt[k]++; end
            if (mcnt[k] > 0) mlast[k] = ment[k][0];
        end
    endtask

    // Compare before the edge (inputs settled), then advance model and DUT.
    task automatic cycle();
        #3;
        check("skid_valid", 128'(vout1), 128'(mcnt[1] != 0));
        check("skid_ready", 128'(rout1), 128'(mrdy(1)));
        check("skid_data",  128'(dout1), 128'(mlast[1][31:0]));
        check("skid_occ",   128'(occ1),  128'(mcnt[1]));
        check("skid_stall", 128'(cnt1),  128'(mstall[1]));
        check("flat_valid", 128'(vout0), 128'(mcnt[0] != 0));
        check("flat_ready", 128'(rout0), 128'(mrdy(0)));
        check("flat_data",  128'(dout0), 128'(mlast[0]));
        check("flat_occ",   128'(occ0),  128'(mcnt[0]));
        check("flat_stall", 128'(cnt0),  128'(mstall[0]));
        model_step(1);
        model_step(0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        vin = '0; rin = '0; clr = '0; scc = '0;
    endtask

    task automatic drive(input int k, input logic v, input logic [95:0] d, input logic r);
        vin[k] = v; din[k] = d; rin[k] = r;
    endtask

    // Reset mid-cycle: outputs must clear with no clock edge.
    task automatic async_reset();
        #1 reset = 1'b1;
        #1;
        check("rst_skid_valid", 128'(vout1), 128'(0));
        check("rst_skid_data",  128'(dout1), 128'(0));
        check("rst_skid_occ",   128'(occ1),  128'(0));
        check("rst_skid_ready", 128'(rout1), 128'(1));
        check("rst_flat_valid", 128'(vout0), 128'(0));
        check("rst_flat_data",  128'(dout0), 128'(0));
        check("rst_flat_ready", 128'(rout0), 128'(1));
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        din[0] = '0; din[1] = '0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        cycle();

        // Streaming through the skid stage
        for (int i = 1; i <= 8; i++) begin
            drive(1, 1'b1, 96'(i), 1'b1);
            cycle();
            check("stream_data", 128'(dout1), 128'(i));
            check("stream_occ",  128'(occ1),  128'(1));
        end
        idle(); rin[1] = 1'b1;
        cycle();

        // Back-pressure: 0xA then 0xB with downstream stalled
        drive(1, 1'b1, 96'hA, 1'b1);
        cycle();
        drive(1, 1'b1, 96'hB, 1'b0);
        cycle();
        check("bp_occ",   128'(occ1),  128'(2));
        check("bp_ready", 128'(rout1), 128'(0));
        vin[1] = 1'b0;
        repeat (3) begin
            cycle();
            check("bp_hold", 128'(dout1), 128'(32'hA));
        end
        rin[1] = 1'b1;
        cycle();
        check("bp_second", 128'(dout1), 128'(32'hB));
        check("bp_ready_back", 128'(rout1), 128'(1));
        cycle();

        // Flush while FULL, then flush while BUSY with a payload offered
        drive(1, 1'b1, 96'hA, 1'b0); cycle();
        drive(1, 1'b1, 96'hB, 1'b0); cycle();
        vin[1] = 1'b0; rin[1] = 1'b1; clr[1] = 1'b1;
        cycle();
        clr[1] = 1'b0;
        check("flush_valid", 128'(vout1), 128'(0));
        check("flush_occ",   128'(occ1),  128'(0));
        check("flush_data",  128'(dout1), 128'(0));
        drive(1, 1'b1, 96'h11, 1'b0); cycle();
        drive(1, 1'b1, 96'h22, 1'b0); clr[1] = 1'b1;
        cycle();
        clr[1] = 1'b0; vin[1] = 1'b0;
        check("flush_drop_occ", 128'(occ1), 128'(0));
        cycle();

        // Skid-less, wide payload: stall then bubble-free replacement
        drive(0, 1'b1, 96'hFEED_0000_0000_0000_0001, 1'b1); cycle();
        drive(0, 1'b0, '0, 1'b0);
        repeat (3) cycle();
        drive(0, 1'b1, 96'h123456789ABCDEF012345678, 1'b1);
        cycle();
        check("flat_replace_data", 128'(dout0), 128'(96'h123456789ABCDEF012345678));
        check("flat_replace_occ",  128'(occ0),  128'(1));
        drive(0, 1'b0, '0, 1'b1);
        cycle();

        // Counter saturation and clear during a stall
        drive(1, 1'b1, 96'h5, 1'b0); cycle();
        vin[1] = 1'b0;
        repeat (20) cycle();
        check("sat_value", 128'(cnt1), 128'(15));
        scc[1] = 1'b1; cycle();
        scc[1] = 1'b0;
        check("sat_clr", 128'(cnt1), 128'(0));
        cycle();
        check("sat_resume", 128'(cnt1), 128'(1));

        // Reset with both stages holding entries
        drive(1, 1'b1, 96'h7, 1'b0); drive(0, 1'b1, 96'h9, 1'b0);
        cycle();
        idle();
        async_reset();
        cycle();

        // Random traffic on both instances
        repeat (3000) begin
            for (int k = 0; k < 2; k++) begin
                vin[k] = 1'($urandom_range(0, 3) != 0);
                rin[k] = 1'($urandom_range(0, 2) != 0);
                din[k] = {$urandom, $urandom, $urandom};
                clr[k] = 1'($urandom_range(0, 31) == 0);
                scc[k] = 1'($urandom_range(0, 63) == 0);
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
